// File: rtl/param_updown_counter.sv
// Up/down counter with a runtime upper bound, selectable wrap/saturate behaviour at the bounds,
// a registered terminal-count pulse and sticky boundary flags.
module param_updown_counter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max_val,
   input  logic              sat_mode,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf,
   output logic              unf,
   output logic              at_max,
   output logic              at_min
);

   localparam int unsigned EW = WIDTH + 1;

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;
   logic             r_unf;

   // One extra bit so that sums and max_val+1 never overflow.
   logic [EW-1:0]    w_cnt_x;
   logic [EW-1:0]    w_step_x;
   logic [EW-1:0]    w_max_x;
   logic [EW-1:0]    w_max_p1;
   logic [EW-1:0]    w_sum;
   logic             w_up_cross;
   logic             w_dn_cross;
   logic             w_step_fits;
   logic             w_out_of_range;
   logic [WIDTH-1:0] w_up_norm;
   logic [WIDTH-1:0] w_dn_norm;
   logic [WIDTH-1:0] w_up_wrap;
   logic [WIDTH-1:0] w_dn_wrap;
   logic [WIDTH-1:0] w_load_clip;

   logic [WIDTH-1:0] w_count_d;
   logic             w_tc_d;
   logic             w_ovf_set;
   logic             w_unf_set;

   assign w_cnt_x  = {1'b0, r_count};
   assign w_step_x = {{(EW - STEP_W){1'b0}}, step};
   assign w_max_x  = {1'b0, max_val};
   assign w_max_p1 = w_max_x + EW'(1);
   assign w_sum    = w_cnt_x + w_step_x;

   assign w_up_cross     = (w_sum > w_max_x);
   assign w_dn_cross     = (w_step_x > w_cnt_x);
   assign w_step_fits    = (w_step_x <= w_max_x);
   assign w_out_of_range = (r_count > max_val);

   // Every result below is provably < 2^WIDTH when selected, so the casts drop only zero bits.
   assign w_up_norm = WIDTH'(w_sum);
   assign w_dn_norm = WIDTH'(w_cnt_x - w_step_x);
   assign w_up_wrap = WIDTH'(w_sum - w_max_p1);
   assign w_dn_wrap = WIDTH'(w_cnt_x + w_max_p1 - w_step_x);

   assign w_load_clip = (load_val > max_val) ? max_val : load_val;

   always_comb begin
      w_count_d = r_count;
      w_tc_d    = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      if (load) begin
         w_count_d = w_load_clip;
      end else if (w_out_of_range) begin
         w_count_d = max_val;
      end else if (en && (step != '0)) begin
         if (up) begin
            if (!w_up_cross) begin
               w_count_d = w_up_norm;
            end else begin
               w_tc_d    = 1'b1;
               w_ovf_set = 1'b1;
               if (sat_mode)         w_count_d = max_val;
               else if (w_step_fits) w_count_d = w_up_wrap;
               else                  w_count_d = '0;
            end
         end else begin
            if (!w_dn_cross) begin
               w_count_d = w_dn_norm;
            end else begin
               w_tc_d    = 1'b1;
               w_unf_set = 1'b1;
               if (sat_mode)         w_count_d = '0;
               else if (w_step_fits) w_count_d = w_dn_wrap;
               else                  w_count_d = max_val;
            end
         end
      end
   end

   // A set on the same edge as clr_flags wins.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_count_d;
         r_tc    <= w_tc_d;
         r_ovf   <= w_ovf_set | (r_ovf & ~clr_flags);
         r_unf   <= w_unf_set | (r_unf & ~clr_flags);
      end
   end

   assign count  = r_count;
   assign tc     = r_tc;
   assign ovf    = r_ovf;
   assign unf    = r_unf;
   assign at_max = (r_count == max_val);
   assign at_min = (r_count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter (default WIDTH=8, STEP_W=4).
module tb_param_updown_counter;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic       up;
   logic [3:0] step;
   logic [7:0] max_val;
   logic       sat_mode;
   logic       load;
   logic [7:0] load_val;
   logic       clr_flags;
   logic [7:0] count;
   logic       tc;
   logic       ovf;
   logic       unf;
   logic       at_max;
   logic       at_min;

   int n_checks = 0;
   int n_pass   = 0;

   param_updown_counter #(
      .WIDTH  (8),
      .STEP_W (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .up        (up),
      .step      (step),
      .max_val   (max_val),
      .sat_mode  (sat_mode),
      .load      (load),
      .load_val  (load_val),
      .clr_flags (clr_flags),
      .count     (count),
      .tc        (tc),
      .ovf       (ovf),
      .unf       (unf),
      .at_max    (at_max),
      .at_min    (at_min)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; load = 1'b1; load_val = 8'd5; en = 1'b1; up = 1'b1; step = 4'd1;
      clr_flags = 1'b1; max_val = 8'd9; sat_mode = 1'b0;
      tick();
      reset_n = 1'b1; load = 1'b0; en = 1'b0; clr_flags = 1'b0;
      n_checks++; if (count !== 8'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL reset_tc got %b exp 0", tc); else n_pass++;
      n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else n_pass++;
      n_checks++; if (unf !== 1'b0) $display("FAIL reset_unf got %b exp 0", unf); else n_pass++;
      n_checks++; if (at_min !== 1'b1) $display("FAIL reset_at_min got %b exp 1", at_min); else n_pass++;
   endtask

   task automatic test_decade_wrap();
      load = 1'b1; load_val = 8'd9;
      tick();
      load = 1'b0;
      n_checks++; if (count !== 8'd9) $display("FAIL dec_load got %0d exp 9", count); else n_pass++;
      n_checks++; if (at_max !== 1'b1) $display("FAIL dec_at_max got %b exp 1", at_max); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL dec_load_tc got %b exp 0", tc); else n_pass++;
      en = 1'b1; up = 1'b1; step = 4'd1;
      tick();
      en = 1'b0;
      n_checks++; if (count !== 8'd0) $display("FAIL dec_wrap_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL dec_wrap_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (ovf !== 1'b1) $display("FAIL dec_wrap_ovf got %b exp 1", ovf); else n_pass++;
      n_checks++; if (unf !== 1'b0) $display("FAIL dec_wrap_unf got %b exp 0", unf); else n_pass++;
      tick();
      n_checks++; if (tc !== 1'b0) $display("FAIL dec_tc_drop got %b exp 0", tc); else n_pass++;
      n_checks++; if (ovf !== 1'b1) $display("FAIL dec_ovf_sticky got %b exp 1", ovf); else n_pass++;
   endtask

   task automatic test_multi_step();
      load = 1'b1; load_val = 8'd8; clr_flags = 1'b1;
      tick();
      load = 1'b0; clr_flags = 1'b0;
      n_checks++; if (count !== 8'd8) $display("FAIL ms_load got %0d exp 8", count); else n_pass++;
      n_checks++; if (ovf !== 1'b0) $display("FAIL ms_clr_ovf got %b exp 0", ovf); else n_pass++;
      en = 1'b1; up = 1'b1; step = 4'd3;
      tick();
      n_checks++; if (count !== 8'd1) $display("FAIL ms_up_count got %0d exp 1", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL ms_up_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (ovf !== 1'b1) $display("FAIL ms_up_ovf got %b exp 1", ovf); else n_pass++;
      up = 1'b0; step = 4'd4;
      tick();
      en = 1'b0;
      n_checks++; if (count !== 8'd7) $display("FAIL ms_dn_count got %0d exp 7", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL ms_dn_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (unf !== 1'b1) $display("FAIL ms_dn_unf got %b exp 1", unf); else n_pass++;
      tick();
      n_checks++; if (tc !== 1'b0) $display("FAIL ms_tc_drop got %b exp 0", tc); else n_pass++;
      n_checks++; if (count !== 8'd7) $display("FAIL ms_hold got %0d exp 7", count); else n_pass++;
   endtask

   task automatic test_saturate();
      sat_mode = 1'b1; load = 1'b1; load_val = 8'd2; clr_flags = 1'b1;
      tick();
      load = 1'b0; clr_flags = 1'b0;
      en = 1'b1; up = 1'b0; step = 4'd3;
      tick();
      n_checks++; if (count !== 8'd0) $display("FAIL sat_dn1_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL sat_dn1_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (unf !== 1'b1) $display("FAIL sat_dn1_unf got %b exp 1", unf); else n_pass++;
      tick();
      en = 1'b0;
      n_checks++; if (count !== 8'd0) $display("FAIL sat_dn2_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL sat_dn2_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (ovf !== 1'b0) $display("FAIL sat_dn2_ovf got %b exp 0", ovf); else n_pass++;
      load = 1'b1; load_val = 8'd9;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1;
      tick();
      en = 1'b0;
      n_checks++; if (count !== 8'd9) $display("FAIL sat_up_count got %0d exp 9", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL sat_up_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (ovf !== 1'b1) $display("FAIL sat_up_ovf got %b exp 1", ovf); else n_pass++;
   endtask

   task automatic test_load_priority();
      sat_mode = 1'b0; load = 1'b1; en = 1'b1; up = 1'b1; step = 4'd1; load_val = 8'd20;
      tick();
      load = 1'b0; en = 1'b0;
      n_checks++; if (count !== 8'd9) $display("FAIL ld_clip got %0d exp 9", count); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL ld_tc got %b exp 0", tc); else n_pass++;
      max_val = 8'd5;
      tick();
      n_checks++; if (count !== 8'd5) $display("FAIL oor_count got %0d exp 5", count); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL oor_tc got %b exp 0", tc); else n_pass++;
      n_checks++; if (unf !== 1'b1) $display("FAIL oor_unf_kept got %b exp 1", unf); else n_pass++;
      max_val = 8'd9;
   endtask

   task automatic test_step_zero();
      en = 1'b1; up = 1'b1; step = 4'd0;
      tick();
      en = 1'b0;
      n_checks++; if (count !== 8'd5) $display("FAIL step0_count got %0d exp 5", count); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL step0_tc got %b exp 0", tc); else n_pass++;
   endtask

   task automatic test_flag_race();
      sat_mode = 1'b0; max_val = 8'd9; load = 1'b1; load_val = 8'd9; clr_flags = 1'b1;
      tick();
      load = 1'b0; clr_flags = 1'b0;
      n_checks++; if (ovf !== 1'b0) $display("FAIL race_pre_clr got %b exp 0", ovf); else n_pass++;
      en = 1'b1; up = 1'b1; step = 4'd1;
      tick();
      en = 1'b0; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; clr_flags = 1'b1;
      tick();
      en = 1'b0;
      n_checks++; if (ovf !== 1'b1) $display("FAIL race_set_wins got %b exp 1", ovf); else n_pass++;
      n_checks++; if (count !== 8'd0) $display("FAIL race_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL race_tc got %b exp 1", tc); else n_pass++;
      tick();
      clr_flags = 1'b0;
      n_checks++; if (ovf !== 1'b0) $display("FAIL race_clear got %b exp 0", ovf); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL race_tc_drop got %b exp 0", tc); else n_pass++;
   endtask

   task automatic test_max_zero();
      max_val = 8'd0; en = 1'b1; up = 1'b1; step = 4'd3;
      tick();
      n_checks++; if (count !== 8'd0) $display("FAIL mz_up_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL mz_up_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (ovf !== 1'b1) $display("FAIL mz_up_ovf got %b exp 1", ovf); else n_pass++;
      n_checks++; if (at_max !== 1'b1) $display("FAIL mz_at_max got %b exp 1", at_max); else n_pass++;
      up = 1'b0; step = 4'd1;
      tick();
      en = 1'b0;
      n_checks++; if (count !== 8'd0) $display("FAIL mz_dn_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b1) $display("FAIL mz_dn_tc got %b exp 1", tc); else n_pass++;
      n_checks++; if (unf !== 1'b1) $display("FAIL mz_dn_unf got %b exp 1", unf); else n_pass++;
      max_val = 8'd9;
   endtask

   task automatic test_reset_mid();
      load = 1'b1; load_val = 8'd5; clr_flags = 1'b1;
      tick();
      load = 1'b0; clr_flags = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1;
      tick();
      tick();
      n_checks++; if (count !== 8'd7) $display("FAIL rm_pre_count got %0d exp 7", count); else n_pass++;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_checks++; if (count !== 8'd0) $display("FAIL rm_count got %0d exp 0", count); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL rm_tc got %b exp 0", tc); else n_pass++;
      n_checks++; if ({ovf, unf} !== 2'b00) $display("FAIL rm_flags got %b exp 00", {ovf, unf}); else n_pass++;
      tick();
      en = 1'b0;
      n_checks++; if (count !== 8'd1) $display("FAIL rm_resume got %0d exp 1", count); else n_pass++;
      n_checks++; if (tc !== 1'b0) $display("FAIL rm_resume_tc got %b exp 0", tc); else n_pass++;
   endtask

   initial begin
      reset_n = 1'b0; en = 1'b0; up = 1'b0; step = 4'd0; max_val = 8'd9; sat_mode = 1'b0;
      load = 1'b0; load_val = 8'd0; clr_flags = 1'b0;
      test_reset();
      test_decade_wrap();
      test_multi_step();
      test_saturate();
      test_load_priority();
      test_step_zero();
      test_flag_race();
      test_max_zero();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter and bound width in bits, WIDTH >= 2.
REQ-002 Parameter STEP_W, default 4: step input width in bits, STEP_W <= WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = up, 0 = down.
REQ-007 step  input  STEP_W  increment/decrement magnitude.
REQ-008 max_val  input  WIDTH  runtime upper bound; legal range is 0..max_val.
REQ-009 sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap modulo max_val+1.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  load value.
REQ-012 clr_flags  input  1  clears the sticky flags.
REQ-013 count  output  WIDTH  registered count.
REQ-014 tc  output  1  registered terminal-count event pulse.
REQ-015 ovf  output  1  sticky up-boundary flag.
REQ-016 unf  output  1  sticky down-boundary flag.
REQ-017 at_max / at_min  output  1 each  combinational: count == max_val / count == 0.

Function
REQ-018 Update priority per edge SHALL be: reset, then load, then out-of-range correction, then en step, then hold.
REQ-019 Load SHALL set count <= min(load_val, max_val) regardless of en, with no tc and no flag change.
REQ-020 If count > max_val (max_val lowered at runtime) and load=0, count SHALL become max_val on the next edge regardless of en, with no tc and no flag change.
REQ-021 en=1 with step=0 SHALL hold count with no tc and no flag change.
REQ-022 Intermediate arithmetic SHALL be WIDTH+1 bits; no implicit truncation.
REQ-023 Up, normal case: if count+step <= max_val, count <= count+step.
REQ-024 Up crossing, wrap mode: count <= count+step-(max_val+1) when step <= max_val, else count <= 0; tc=1; ovf set.
REQ-025 Up crossing, saturate mode: count <= max_val; tc=1; ovf set; this also applies when count is already at max_val.
REQ-026 Down, normal case: if step <= count, count <= count-step.
REQ-027 Down crossing, wrap mode: count <= count+(max_val+1)-step when step <= max_val, else count <= max_val; tc=1; unf set.
REQ-028 Down crossing, saturate mode: count <= 0; tc=1; unf set; this also applies when count is already 0.
REQ-029 tc SHALL be high for exactly the cycle following a crossing edge, aligned with the updated count, and low otherwise.
REQ-030 Consecutive crossings SHALL give consecutive tc cycles.
REQ-031 ovf/unf SHALL stay set until clr_flags=1; a clear takes effect on the next edge.
REQ-032 If clr_flags=1 and a crossing occur on the same edge, the set SHALL win.
REQ-033 The new count SHALL be visible one edge after the qualifying inputs, i.e. latency 1.
REQ-034 With max_val=0 every nonzero step SHALL be a crossing and count SHALL remain 0.

Reset
REQ-035 reset_n=0 at an edge SHALL force count=0, tc=0, ovf=0, unf=0, overriding load, en and clr_flags.
REQ-036 Asserting reset_n mid-count SHALL discard any in-flight step, with no tc on the following cycle.
REQ-037 Outputs SHALL be undefined only before the first reset edge; no asynchronous path is allowed.

Verification
REQ-038 Decade wrap: max_val=9, sat_mode=0, up=1, step=1, count=9, en=1 -> count=0, tc=1 for 1 cycle, ovf=1.
REQ-039 Multi-step wrap: max_val=9, count=8, step=3, up=1 -> 1; then up=0, step=4 -> 7, tc=1, unf=1.
REQ-040 Saturate: sat_mode=1, max_val=9, count=2, up=0, step=3 for 2 cycles -> count 0, 0; tc=1 both cycles; unf=1; ovf=0.
REQ-041 Load priority: load=1, en=1, load_val=20, max_val=9 -> count=9, tc=0; then max_val=5 with en=0 -> count=5 next edge.
REQ-042 Flag race: ovf=1, clr_flags=1 with an up crossing on the same edge -> ovf stays 1; clr_flags=1 alone next edge -> ovf=0.
REQ-043 Reset mid-run: counting up at count=7 with en=1, then reset_n=0 for one edge -> count=0, tc=0, ovf=0, unf=0; counting resumes from 0 after release.
